pc_gen: RTL
===========

# pc_gen

Parametrised fetch-address generator; successor to the single-register program counter. Holds the architectural fetch PC and presents it to instruction memory with a valid/ready handshake. Arbitrates trap, flush, stall and sequential advance, and optionally predicts taken branches with a small direct-mapped branch target buffer (BTB). Sits at the head of the fetch stage. It is redirected by the execute unit (flush) and by the trap/CSR unit (trap).

## Interface
- DWIDTH, 32: PC and target width.
- RESET_VECTOR, 32'h0000_0000: PC value loaded on reset. Must be 4-byte aligned.
- BTB_ENTRIES, 16: BTB depth. Power of two, ≥ 2. Used only when PC_BTB_EN is defined.

- Clk_Core  in  1  core clock.
- Rst_Core_N  in  1  asynchronous, active-low reset.
- Stall  in  1  hold request from decode.
- Flush  in  1  branch/jump redirect from execute.
- Flush_Target  in  DWIDTH  redirect address.
- Trap  in  1  exception/interrupt redirect.
- Trap_Target  in  DWIDTH  trap vector address.
- Fetch_Ready  in  1  instruction memory accepts request.
- Btb_Update  in  1  resolved-branch update strobe.
- Btb_Update_Pc  in  DWIDTH  PC of the resolved branch.
- Btb_Update_Target  in  DWIDTH  resolved target.
- Btb_Update_Taken  in  1  branch was taken.
- Fetch_Valid  out  1  Program_Count is a valid fetch request.
- Program_Count  out  DWIDTH  current fetch PC.
- Pred_Taken  out  1  BTB hit on Program_Count.
- Pred_Target  out  DWIDTH  predicted next PC.
- Misalign_Err  out  1  one-cycle pulse: the accepted redirect target had bits [1:0] ≠ 0.

## Operation
- State machine has three states:
  - BOOT: entered on reset. Fetch_Valid=0. Goes to FETCH unconditionally on the next edge.
  - FETCH: Fetch_Valid=1.
  - BUBBLE: Fetch_Valid=0 for exactly one cycle after any redirect, then FETCH.
- Next-PC priority, highest first:
  1. Trap → Trap_Target, next state BUBBLE.
  2. Flush → Flush_Target, next state BUBBLE.
  3. Stall, or FETCH with Fetch_Ready=0 → hold PC.
  4. FETCH with Fetch_Ready=1 → Pred_Target.
- BOOT and BUBBLE without a redirect hold PC.
- Trap and Flush act in any state and ignore Stall and Fetch_Ready.
- Redirect targets are loaded with bits [1:0] cleared. Misalign_Err is registered and pulses high the cycle after a redirect whose target had nonzero low bits.
- Pred_Target = BTB hit ? stored target : Program_Count + 4. The sum is modulo 2^DWIDTH, so 0xFFFF_FFFC wraps to 0x0000_0000.
- Handshake rule: while Fetch_Valid=1 and Fetch_Ready=0, Program_Count must not change unless a redirect occurs.

## Timing
- Reset values: Program_Count=RESET_VECTOR, Fetch_Valid=0, Misalign_Err=0, Pred_Taken=0, all BTB valid bits 0, state BOOT.
- Reset is asserted asynchronously. Deassertion is sampled on Clk_Core. Reset mid-operation discards any in-flight request.
- First fetch request: Fetch_Valid rises on the first edge after reset release.
- Redirect latency: Trap/Flush sampled at edge N sets Program_Count=target after edge N. Fetch_Valid=0 for the following cycle and returns to 1 after edge N+1.
- BTB lookup is combinational on Program_Count. Pred_Taken and Pred_Target are valid in the same cycle.
- BTB write lands on the edge after Btb_Update. A same-cycle lookup at the same index sees the old entry.
- Simultaneous Trap and Flush: Trap wins, and Misalign_Err reflects Trap_Target only.

## Configuration
- PC_BTB_EN defined: BTB compiled in.
  - Direct-mapped. Index = PC[log2(BTB_ENTRIES)+1:2]; tag = PC[DWIDTH-1:log2(BTB_ENTRIES)+2].
  - Each entry holds a valid bit, the tag and the target.
  - Btb_Update with Taken=1 writes the entry valid.
  - Btb_Update with Taken=0 clears the valid bit only if the stored tag matches.
  - Flush and Trap never clear the BTB.
- PC_BTB_EN undefined: no BTB storage. Pred_Taken tied to 0. Pred_Target = Program_Count + 4. Btb_Update* inputs are ignored.

## Structure
- Shared core package holds:
  - pc_state_t enum (BOOT, FETCH, BUBBLE)
  - constant PC_INC = 4
  - btb_entry_t struct (valid, tag, target); its tag width is derived from DWIDTH and BTB_ENTRIES.
- One sub-module, pc_btb: storage, lookup and update. It is instantiated only under PC_BTB_EN.
- pc_gen keeps the state machine, priority mux and adder.

## Test plan
- Reset release with RESET_VECTOR=0x100 and Fetch_Ready=1 → one cycle Fetch_Valid=0, then PC sequence 0x100, 0x104, 0x108.
- Fetch_Ready=0 for 3 cycles at PC 0x200 → PC stays 0x200 and Fetch_Valid stays 1. PC advances to 0x204 the cycle after Ready returns.
- Stall=1 with simultaneous Trap=1, Trap_Target=0x80, Flush=1, Flush_Target=0x400 → PC=0x80 next cycle, one bubble, then 0x84.
- Flush with Flush_Target=0x303 → PC=0x300 and Misalign_Err pulses for exactly one cycle.
- PC_BTB_EN: Btb_Update for Pc 0x110, Target 0x500, Taken=1, then fetch reaches 0x110 → Pred_Taken=1 and next PC is 0x500. A later update with Taken=0 → next PC is 0x114.
- PC at 0xFFFF_FFFC with Ready=1 → next PC 0x0000_0000.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch-address generator: state encoding, PC increment
// and BTB entry layout for the default configuration.
package pc_gen_pkg;

    localparam int unsigned PC_INC         = 4;
    localparam int unsigned PC_DWIDTH      = 32;
    localparam int unsigned PC_BTB_ENTRIES = 16;

    // Tag covers every PC bit above the index and the two byte-offset bits.
    function automatic int unsigned btb_tag_w(input int unsigned dwidth,
                                              input int unsigned entries);
        return dwidth - $clog2(entries) - 2;
    endfunction

    localparam int unsigned PC_BTB_TAG_W = btb_tag_w(PC_DWIDTH, PC_BTB_ENTRIES);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        FETCH  = 2'd1,
        BUBBLE = 2'd2
    } pc_state_t;

    typedef struct packed {
        logic                    valid;
        logic [PC_BTB_TAG_W-1:0] tag;
        logic [PC_DWIDTH-1:0]    target;
    } btb_entry_t;

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer: combinational lookup on the fetch PC,
// registered update from resolved branches. Instantiated only with PC_BTB_EN.
module pc_btb
    import pc_gen_pkg::*;
#(
    parameter int unsigned DWIDTH      = 32,
    parameter int unsigned BTB_ENTRIES = 16
) (
    input  logic              Clk_Core,
    input  logic              Rst_Core_N,
    input  logic [DWIDTH-1:0] Lookup_Pc,
    output logic              Hit,
    output logic [DWIDTH-1:0] Hit_Target,
    input  logic              Update,
    input  logic [DWIDTH-1:0] Update_Pc,
    input  logic [DWIDTH-1:0] Update_Target,
    input  logic              Update_Taken
);

    localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = btb_tag_w(DWIDTH, BTB_ENTRIES);

    // Same layout as btb_entry_t, sized from this instance's parameters.
    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DWIDTH-1:0] target;
    } entry_t;

    entry_t r_mem [BTB_ENTRIES];

    logic [IDX_W-1:0] w_lk_idx;
    logic [TAG_W-1:0] w_lk_tag;
    logic [IDX_W-1:0] w_upd_idx;
    logic [TAG_W-1:0] w_upd_tag;
    entry_t           w_lk_entry;
    logic             w_unused_lsb;

    assign w_lk_idx     = Lookup_Pc[IDX_W+1:2];
    assign w_lk_tag     = Lookup_Pc[DWIDTH-1:IDX_W+2];
    assign w_upd_idx    = Update_Pc[IDX_W+1:2];
    assign w_upd_tag    = Update_Pc[DWIDTH-1:IDX_W+2];
    assign w_unused_lsb = ^{Lookup_Pc[1:0], Update_Pc[1:0]};

    assign w_lk_entry = r_mem[w_lk_idx];
    assign Hit        = w_lk_entry.valid && (w_lk_entry.tag == w_lk_tag);
    assign Hit_Target = w_lk_entry.target;

    // Not-taken only invalidates when it resolves the branch that owns the slot.
    always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
        if (!Rst_Core_N) begin
            r_mem <= '{default: '0};
        end else if (Update) begin
            if (Update_Taken) begin
                r_mem[w_upd_idx] <= '{valid: 1'b1, tag: w_upd_tag, target: Update_Target};
            end else if (r_mem[w_upd_idx].tag == w_upd_tag) begin
                r_mem[w_upd_idx].valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch-address generator: trap/flush/stall/advance arbitration with a valid/ready
// fetch handshake. Optional BTB prediction is compiled in when PC_BTB_EN is defined.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned       DWIDTH       = 32,
    parameter logic [DWIDTH-1:0] RESET_VECTOR = '0,
    parameter int unsigned       BTB_ENTRIES  = 16
) (
    input  logic              Clk_Core,
    input  logic              Rst_Core_N,
    input  logic              Stall,
    input  logic              Flush,
    input  logic [DWIDTH-1:0] Flush_Target,
    input  logic              Trap,
    input  logic [DWIDTH-1:0] Trap_Target,
    input  logic              Fetch_Ready,
    input  logic              Btb_Update,
    input  logic [DWIDTH-1:0] Btb_Update_Pc,
    input  logic [DWIDTH-1:0] Btb_Update_Target,
    input  logic              Btb_Update_Taken,
    output logic              Fetch_Valid,
    output logic [DWIDTH-1:0] Program_Count,
    output logic              Pred_Taken,
    output logic [DWIDTH-1:0] Pred_Target,
    output logic              Misalign_Err
);

    pc_state_t         r_state;
    pc_state_t         w_next_state;
    logic [DWIDTH-1:0] r_pc;
    logic [DWIDTH-1:0] w_next_pc;
    logic              r_misalign;
    logic              w_next_misalign;
    logic [DWIDTH-1:0] w_pc_inc;
    logic              w_btb_hit;
    logic [DWIDTH-1:0] w_btb_target;
    logic [DWIDTH-1:0] w_pred_target;

    assign w_pc_inc = r_pc + DWIDTH'(PC_INC);

`ifdef PC_BTB_EN
    pc_btb #(
        .DWIDTH      (DWIDTH),
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .Clk_Core      (Clk_Core),
        .Rst_Core_N    (Rst_Core_N),
        .Lookup_Pc     (r_pc),
        .Hit           (w_btb_hit),
        .Hit_Target    (w_btb_target),
        .Update        (Btb_Update),
        .Update_Pc     (Btb_Update_Pc),
        .Update_Target (Btb_Update_Target),
        .Update_Taken  (Btb_Update_Taken)
    );
`else
    logic w_unused_btb;

    assign w_btb_hit    = 1'b0;
    assign w_btb_target = w_pc_inc;
    assign w_unused_btb = ^{Btb_Update, Btb_Update_Pc, Btb_Update_Target, Btb_Update_Taken};
`endif

    assign w_pred_target = w_btb_hit ? w_btb_target : w_pc_inc;

    always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
        if (!Rst_Core_N) begin
            r_state    <= BOOT;
            r_pc       <= RESET_VECTOR;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_pc       <= w_next_pc;
            r_misalign <= w_next_misalign;
        end
    end

    // Redirects override everything, in any state; only FETCH ever advances the PC.
    always_comb begin
        w_next_state    = r_state;
        w_next_pc       = r_pc;
        w_next_misalign = 1'b0;
        if (Trap) begin
            w_next_state    = BUBBLE;
            w_next_pc       = {Trap_Target[DWIDTH-1:2], 2'b00};
            w_next_misalign = |Trap_Target[1:0];
        end else if (Flush) begin
            w_next_state    = BUBBLE;
            w_next_pc       = {Flush_Target[DWIDTH-1:2], 2'b00};
            w_next_misalign = |Flush_Target[1:0];
        end else begin
            case (r_state)
                BOOT:    w_next_state = FETCH;
                BUBBLE:  w_next_state = FETCH;
                FETCH: begin
                    if (!Stall && Fetch_Ready) begin
                        w_next_pc = w_pred_target;
                    end
                end
                default: w_next_state = BOOT;
            endcase
        end
    end

    assign Fetch_Valid   = (r_state == FETCH);
    assign Program_Count = r_pc;
    assign Pred_Taken    = w_btb_hit;
    assign Pred_Target   = w_pred_target;
    assign Misalign_Err  = r_misalign;

endmodule
